// File: rtl/cic_decimator_param.sv
// cic_decimator_param
//   N-stage CIC decimator with runtime decimation ratio, gain-normalising
//   arithmetic right shift, round-half-up, output saturation and a
//   decimated-rate clock-enable waveform.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid, d_in    - input sample strobe and signed IN_W-bit sample
//   decimation_ratio  - runtime R (0 behaves as 1), latched per frame
//   out_shift         - right shift applied to the comb result
//   out_valid, d_out  - one-clk strobe and signed OUT_W-bit held sample
//   sat               - high with out_valid when the sample was clamped
//   d_clk             - high from capture until the count passes R/2
module cic_decimator_param #(
  parameter int N_STAGES = 5,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 64,
  parameter int SHIFT_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    d_in,
  input  logic [15:0]        decimation_ratio,
  input  logic [SHIFT_W-1:0] out_shift,
  output logic               out_valid,
  output logic [OUT_W-1:0]   d_out,
  output logic               sat,
  output logic               d_clk
);

  localparam logic signed [ACC_W:0] ONE   = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] integ_q [N_STAGES];
  logic signed [ACC_W-1:0] integ_d [N_STAGES];
  logic signed [ACC_W-1:0] comb_q  [N_STAGES];
  logic signed [ACC_W-1:0] comb_d  [N_STAGES];
  logic signed [ACC_W-1:0] dly_q   [N_STAGES];
  logic signed [ACC_W-1:0] dly_d   [N_STAGES];
  logic signed [ACC_W-1:0] comb_x  [N_STAGES];
  logic [N_STAGES-1:0]     comb_xv;
  logic [N_STAGES-1:0]     comb_v_q, comb_v_d;
  logic signed [ACC_W-1:0] comb_in_q, comb_in_d;
  logic                    cin_v_q, cin_v_d;
  logic                    cap_q, cap_d;

  logic [15:0]             count_q, count_d;
  logic [15:0]             ratio_q, ratio_d;
  logic [15:0]             ratio_in, r_eff;
  logic                    loaded_q, loaded_d;

  logic signed [ACC_W:0]   wide, rnd, y;
  logic [OUT_W-1:0]        d_out_q, d_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sat_q, sat_d;
  logic                    d_clk_q, d_clk_d;

  // Front end: integrators, sample counter, ratio latch, d_clk.
  always_comb begin
    ratio_in = (decimation_ratio == '0) ? 16'd1 : decimation_ratio;
    // Until the first latch after reset, the live input stands in for R_l.
    r_eff    = loaded_q ? ratio_q : ratio_in;
    integ_d  = integ_q;
    count_d  = count_q;
    ratio_d  = loaded_q ? ratio_q : ratio_in;
    loaded_d = 1'b1;
    cap_d    = 1'b0;
    d_clk_d  = d_clk_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + {{(ACC_W-IN_W){d_in[IN_W-1]}}, d_in};
      for (int unsigned k = 1; k < N_STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      if (count_q == r_eff - 16'd1) begin
        count_d = '0;
        cap_d   = 1'b1;
        ratio_d = ratio_in;
        d_clk_d = 1'b1;
      end else begin
        count_d = count_q + 16'd1;
        if (count_q == (r_eff >> 1)) d_clk_d = 1'b0;
      end
    end
  end

  // Comb pipeline. The capture strobe is registered once, so the comb input
  // register reads integ_q, which by then holds the post-update I_N.
  always_comb begin
    comb_in_d = cap_q ? integ_q[N_STAGES-1] : comb_in_q;
    cin_v_d   = cap_q;
    comb_x[0] = comb_in_q;
    comb_xv[0] = cin_v_q;
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      comb_x[k]  = comb_q[k-1];
      comb_xv[k] = comb_v_q[k-1];
    end
    comb_d   = comb_q;
    dly_d    = dly_q;
    comb_v_d = comb_xv;
    for (int unsigned k = 0; k < N_STAGES; k++) begin
      if (comb_xv[k]) begin
        comb_d[k] = comb_x[k] - dly_q[k];
        dly_d[k]  = comb_x[k];
      end
    end
  end

  // Output stage: round half up, shift, saturate.
  always_comb begin
    wide = {comb_q[N_STAGES-1][ACC_W-1], comb_q[N_STAGES-1]};
    rnd  = '0;
    if (out_shift != '0) rnd = ONE <<< (out_shift - SHIFT_W'(1));
    y           = (wide + rnd) >>> out_shift;
    d_out_d     = d_out_q;
    sat_d       = 1'b0;
    out_valid_d = comb_v_q[N_STAGES-1];
    if (comb_v_q[N_STAGES-1]) begin
      if (y > MAX_V) begin
        d_out_d = {1'b0, {(OUT_W-1){1'b1}}};
        sat_d   = 1'b1;
      end else if (y < MIN_V) begin
        d_out_d = {1'b1, {(OUT_W-1){1'b0}}};
        sat_d   = 1'b1;
      end else begin
        d_out_d = y[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      comb_v_q    <= '0;
      comb_in_q   <= '0;
      cin_v_q     <= 1'b0;
      cap_q       <= 1'b0;
      count_q     <= '0;
      ratio_q     <= '0;
      loaded_q    <= 1'b0;
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      d_clk_q     <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      comb_q      <= comb_d;
      dly_q       <= dly_d;
      comb_v_q    <= comb_v_d;
      comb_in_q   <= comb_in_d;
      cin_v_q     <= cin_v_d;
      cap_q       <= cap_d;
      count_q     <= count_d;
      ratio_q     <= ratio_d;
      loaded_q    <= loaded_d;
      d_out_q     <= d_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      d_clk_q     <= d_clk_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d_out     = d_out_q;
  assign sat       = sat_q;
  assign d_clk     = d_clk_q;

endmodule

// File: tb/tb_cic_decimator_param.sv
// tb_cic_decimator_param
//   Scoreboard bench for cic_decimator_param (N=5, IN_W=8, OUT_W=16).
//   Stimulus pushes hand-computed expected outputs; a negedge monitor pops
//   one entry per out_valid. Integrator stages 2..N use registered values,
//   so the impulse response is the textbook CIC response delayed by N-1
//   input samples; the tables below include that delay.
module tb_cic_decimator_param;
  localparam int N       = 5;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 16;
  localparam int ACC_W   = 64;
  localparam int SHIFT_W = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [IN_W-1:0]    d_in = '0;
  logic [15:0]        decimation_ratio = 16'd4;
  logic [SHIFT_W-1:0] out_shift = '0;
  logic               out_valid;
  logic [OUT_W-1:0]   d_out;
  logic               sat;
  logic               d_clk;

  cic_decimator_param #(
    .N_STAGES(N), .IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in),
    .decimation_ratio(decimation_ratio), .out_shift(out_shift),
    .out_valid(out_valid), .d_out(d_out), .sat(sat), .d_clk(d_clk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [OUT_W-1:0] val;
    logic                    sat;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cap_edge = 0;
  bit lat_armed = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard pop per output strobe.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got d_out=%0d required no output (t=%0t)",
                 $signed(d_out), $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("d_out", longint'($signed(d_out)), longint'(e.val));
        check("sat", longint'(sat), longint'(e.sat));
      end
      if (lat_armed) begin
        check("latency", longint'(cyc - cap_edge), longint'(N + 2));
        lat_armed = 1'b0;
      end
    end
  end

  task automatic step(input logic v, input logic [IN_W-1:0] d);
    in_valid = v;
    d_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic push(input int v, input logic s);
    exp_t e;
    e.val = OUT_W'(v);
    e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    repeat (N + 8) step(1'b0, '0);
    check("drain_empty", longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // DC +100, R=4, shift 10: steps of sum(h) = 0, 56, 512, 968, 1024 (x100)
  // rounded and shifted by 10.
  task automatic run_dc(input bit gaps);
    int tbl[10] = '{0, 5, 50, 95, 100, 100, 100, 100, 100, 100};
    decimation_ratio = 16'd4;
    out_shift        = 7'd10;
    do_reset();
    foreach (tbl[i]) push(tbl[i], 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'd100);
      if (i == 3) begin
        cap_edge  = cyc;
        lat_armed = 1'b1;
      end
      if (gaps) begin
        step(1'b0, 8'd77);
        step(1'b0, 8'd77);
      end
    end
    drain();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_d_out", longint'(d_out), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_d_clk", longint'(d_clk), 0);

    // DC gain, continuous valid
    run_dc(1'b0);

    // Impulse, R=2, shift 0: outputs 0,0,5,10,1,0,0
    begin
      int tbl[7] = '{0, 0, 5, 10, 1, 0, 0};
      decimation_ratio = 16'd2;
      out_shift        = 7'd0;
      do_reset();
      foreach (tbl[i]) push(tbl[i], 1'b0);
      step(1'b1, 8'd1);
      repeat (13) step(1'b1, 8'd0);
      drain();
    end

    // Negative impulse, shift 1 (round half up): -5/2 -> -2, -10/2 -> -5, -1/2 -> 0
    begin
      int tbl[7] = '{0, 0, -2, -5, 0, 0, 0};
      decimation_ratio = 16'd2;
      out_shift        = 7'd1;
      do_reset();
      foreach (tbl[i]) push(tbl[i], 1'b0);
      step(1'b1, 8'hFF);
      repeat (13) step(1'b1, 8'd0);
      drain();
    end

    // Ratio 4 -> 8 written at count=1; d_clk after each of 12 valid inputs.
    begin
      logic exp_dclk[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      decimation_ratio = 16'd4;
      out_shift        = 7'd0;
      do_reset();
      push(0, 1'b0);
      push(0, 1'b0);
      for (int i = 0; i < 12; i++) begin
        step(1'b1, 8'd0);
        if (i == 0) decimation_ratio = 16'd8;
        check("d_clk_ratio_change", longint'(d_clk), longint'(exp_dclk[i]));
      end
      drain();
    end

    // Ratio 0 behaves as 1: output is input delayed by N-1 samples; d_clk stays high.
    begin
      int tbl[8] = '{0, 0, 0, 0, 3, 3, 3, 3};
      decimation_ratio = 16'd0;
      out_shift        = 7'd0;
      do_reset();
      foreach (tbl[i]) push(tbl[i], 1'b0);
      for (int i = 0; i < 8; i++) begin
        step(1'b1, 8'd3);
        check("d_clk_r1", longint'(d_clk), 1);
      end
      drain();
    end

    // Saturation, R=16, shift 0
    decimation_ratio = 16'd16;
    out_shift        = 7'd0;
    do_reset();
    repeat (3) push(-32768, 1'b1);
    repeat (48) step(1'b1, 8'h80);
    drain();
    do_reset();
    repeat (3) push(32767, 1'b1);
    repeat (48) step(1'b1, 8'd127);
    drain();

    // Valid gaps 1-0-0: identical outputs, garbage d_in ignored
    run_dc(1'b1);

    // Reset with tokens in flight, then re-run DC
    decimation_ratio = 16'd4;
    out_shift        = 7'd10;
    do_reset();
    repeat (9) step(1'b1, 8'd100);
    rst = 1'b1;
    step(1'b0, '0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_d_out", longint'(d_out), 0);
    check("midrst_sat", longint'(sat), 0);
    check("midrst_d_clk", longint'(d_clk), 0);
    rst = 1'b0;
    repeat (N + 8) step(1'b0, '0);
    run_dc(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
